// File: rtl/cnt_sched_if.sv
// rtl/cnt_sched_if.sv - requester and counter-control signal bundle for cnt_sched
interface cnt_sched_if;
  logic [1:0] req;
  logic [7:0] val0;
  logic [7:0] val1;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       busy;
  logic       ctr_rst;
  logic       ctr_en;
  logic [7:0] ctr_load;
  logic [7:0] ctr_count;

  modport slave (
    input  req, val0, val1, ctr_count,
    output gnt, done, busy, ctr_rst, ctr_en, ctr_load
  );

  modport master (
    output req, val0, val1, ctr_count,
    input  gnt, done, busy, ctr_rst, ctr_en, ctr_load
  );
endinterface

// File: rtl/cnt_sched.sv
// rtl/cnt_sched.sv - two-requester scheduler driving an external 8-bit up-counter to terminal count
// Define CNT_SCHED_RR_EN for round-robin arbitration; fixed priority (requester 0) otherwise.
module cnt_sched (
  input  logic       clk,
  input  logic       rst,
  cnt_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t     state;
  logic       owner;
  logic [7:0] lat;
  logic       win;
  logic       owner_req;

`ifdef CNT_SCHED_RR_EN
  // last holds the requester served most recently; reset to 1 so requester 0 wins first
  logic last;

  always_comb begin
    win = (bus.req == 2'b11) ? ~last : bus.req[1];
  end

  always_ff @(posedge clk) begin
    if (rst)
      last <= 1'b1;
    else if (state == IDLE && |bus.req)
      last <= win;
  end
`else
  always_comb begin
    win = ~bus.req[0];
  end
`endif

  assign owner_req    = owner ? bus.req[1] : bus.req[0];
  assign bus.ctr_load = lat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      lat         <= 8'h00;
      bus.gnt     <= 2'b00;
      bus.done    <= 2'b00;
      bus.busy    <= 1'b0;
      bus.ctr_rst <= 1'b1;
      bus.ctr_en  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 2'b00;
          if (|bus.req) begin
            state       <= LOAD;
            owner       <= win;
            lat         <= win ? bus.val1 : bus.val0;
            bus.gnt     <= win ? 2'b10 : 2'b01;
            bus.busy    <= 1'b1;
            bus.ctr_rst <= 1'b0;
            bus.ctr_en  <= 1'b1;
          end
        end
        LOAD, RUN: begin
          // owner withdrawal aborts even on the terminal-count cycle
          if (!owner_req) begin
            state       <= IDLE;
            bus.gnt     <= 2'b00;
            bus.busy    <= 1'b0;
            bus.ctr_rst <= 1'b1;
            bus.ctr_en  <= 1'b0;
          end else if (state == LOAD) begin
            state      <= RUN;
            bus.ctr_en <= 1'b0;
          end else if (bus.ctr_count == 8'hFF) begin
            state       <= DONE;
            bus.done    <= owner ? 2'b10 : 2'b01;
            bus.ctr_rst <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 2'b00;
          bus.gnt  <= 2'b00;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cnt_sched.sv
// tb/tb_cnt_sched.sv - randomized self-checking bench for cnt_sched with an external counter model
module tb_cnt_sched;
  logic clk;
  logic rst;
  logic [7:0] cnt;
  int n_tests;
  int n_fail;
  logic model_last;

  cnt_sched_if bus ();

  cnt_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // the counter the scheduler controls: sync reset, then load, else increment
  always_ff @(posedge clk) begin
    if (bus.ctr_rst)
      cnt <= 8'h00;
    else if (bus.ctr_en)
      cnt <= bus.ctr_load;
    else
      cnt <= cnt + 8'h01;
  end
  assign bus.ctr_count = cnt;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"}, int'(bus.gnt), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_ctr_rst"}, int'(bus.ctr_rst), 1);
    chk({tag, "_ctr_en"}, int'(bus.ctr_en), 0);
  endtask

  // Called at a negedge in an IDLE cycle; returns at a negedge in the next IDLE cycle.
  // abort_k: -1 none, -2 random, else RUN index at which the request is withdrawn.
  task automatic run_txn(input logic [1:0] r, input logic [7:0] v0, input logic [7:0] v1,
                         input int abort_k, input bit pulse, input bit hold);
    logic       w;
    logic [1:0] oh;
    logic [7:0] v;
    int         nrun;
    int         ak;
`ifdef CNT_SCHED_RR_EN
    w = (r == 2'b11) ? ~model_last : r[1];
    model_last = w;
`else
    w = ~r[0];
`endif
    v    = w ? v1 : v0;
    oh   = w ? 2'b10 : 2'b01;
    nrun = 256 - int'(v);
    ak   = abort_k;
    if (ak == -2)
      ak = (nrun >= 2 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, nrun - 2)) : -1;
    bus.req  = r;
    bus.val0 = v0;
    bus.val1 = v1;
    step();
    chk("load_gnt", int'(bus.gnt), int'(oh));
    chk("load_busy", int'(bus.busy), 1);
    chk("load_en", int'(bus.ctr_en), 1);
    chk("load_rst", int'(bus.ctr_rst), 0);
    chk("load_val", int'(bus.ctr_load), int'(v));
    chk("load_done", int'(bus.done), 0);
    // vals change after grant must not disturb the latched start value
    bus.val0 = 8'($urandom);
    bus.val1 = 8'($urandom);
    step();
    for (int k = 0; k < nrun; k++) begin
      chk("run_cnt", int'(bus.ctr_count), int'(v) + k);
      chk("run_gnt", int'(bus.gnt), int'(oh));
      chk("run_done", int'(bus.done), 0);
      if (k == 0)
        chk("run_en", int'(bus.ctr_en), 0);
      if (k == ak) begin
        bus.req = 2'b00;
        step();
        chk_idle("abort");
        return;
      end
      if (pulse && k == 1)
        bus.req = 2'b11;
      if (pulse && k == 3)
        bus.req = r;
      step();
    end
    chk("done_pulse", int'(bus.done), int'(oh));
    chk("done_gnt", int'(bus.gnt), int'(oh));
    chk("done_busy", int'(bus.busy), 1);
    chk("done_ctr_rst", int'(bus.ctr_rst), 1);
    if (!hold)
      bus.req = 2'b00;
    step();
    chk_idle("post_done");
  endtask

  initial begin
    logic [1:0] r;
    logic [7:0] v0;
    logic [7:0] v1;
    int         sel;
    n_tests    = 0;
    n_fail     = 0;
    model_last = 1'b1;
    rst        = 1'b1;
    bus.req    = 2'b00;
    bus.val0   = 8'h00;
    bus.val1   = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    chk("reset_load", int'(bus.ctr_load), 0);
    rst = 1'b0;
    step();
    chk_idle("idle");

    run_txn(2'b01, 8'hFC, 8'h33, -1, 1'b0, 1'b0);
    run_txn(2'b10, 8'h44, 8'hFF, -1, 1'b0, 1'b0);
    run_txn(2'b11, 8'hFE, 8'hFE, -1, 1'b0, 1'b1);
    run_txn(2'b11, 8'hFE, 8'hFE, -1, 1'b0, 1'b1);
    run_txn(2'b11, 8'hFE, 8'hFE, -1, 1'b0, 1'b0);
    run_txn(2'b01, 8'h10, 8'h00, 2, 1'b0, 1'b0);
    run_txn(2'b01, 8'hF0, 8'h00, -1, 1'b1, 1'b0);
    run_txn(2'b01, 8'h00, 8'h00, -1, 1'b0, 1'b0);

    // reset in the 100th RUN cycle of a val=00 run, with both requests held through it
    bus.req  = 2'b01;
    bus.val0 = 8'h00;
    step();
    chk("rst_load_gnt", int'(bus.gnt), 1);
    step();
    repeat (99) step();
    chk("rst_run_cnt", int'(bus.ctr_count), 99);
    rst     = 1'b1;
    bus.req = 2'b11;
    step();
    chk_idle("mid_rst");
    chk("mid_rst_load", int'(bus.ctr_load), 0);
    rst        = 1'b0;
    model_last = 1'b1;
    run_txn(2'b11, 8'hFE, 8'hFE, -1, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      r   = 2'($urandom_range(1, 3));
      sel = $urandom_range(0, 9);
      v0  = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom_range(230, 255));
      sel = $urandom_range(0, 9);
      v1  = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom_range(230, 255));
      run_txn(r, v0, v1, -2,
              (r != 2'b11) && (v0 < 8'hF8) && (v1 < 8'hF8) && ($urandom_range(0, 1) == 1),
              $urandom_range(0, 1) == 1);
    end
    bus.req = 2'b00;
    step();
    chk_idle("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cnt_sched.md
CNT_SCHED -- requirements
Module: cnt_sched

Interface
REQ-001 SHALL have port: clk  input  1  clock; all logic on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: req  input  2  per-requester run request; bit i belongs to requester i; level-sensitive.
REQ-004 SHALL have port: val0  input  8  start value for requester 0; sampled at grant.
REQ-005 SHALL have port: val1  input  8  start value for requester 1; sampled at grant.
REQ-006 SHALL have port: gnt  output  2  one-hot grant, registered; high from grant until DONE exits or abort.
REQ-007 SHALL have port: done  output  2  one-cycle terminal-count pulse to the granted requester, registered.
REQ-008 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-009 SHALL have port: ctr_rst  output  1  drives the counter's sync reset.
REQ-010 SHALL have port: ctr_en  output  1  drives the counter's load enable; load has priority over increment.
REQ-011 SHALL have port: ctr_load  output  8  load value presented to the counter.
REQ-012 SHALL have port: ctr_count  input  8  current counter value.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, RUN, DONE.
REQ-014 IDLE: ctr_rst=1, ctr_en=0; if any req bit is high, arbitrate, set gnt, latch the winner's val into an 8-bit register, go to LOAD.
REQ-015 LOAD: ctr_rst=0, ctr_en=1, ctr_load=latched value; go to RUN unconditionally; the counter holds the latched value in the first RUN cycle.
REQ-016 RUN: ctr_rst=0, ctr_en=0, so the counter increments by 1 each cycle; when ctr_count==8'hFF, go to DONE.
REQ-017 DONE: ctr_rst=1; done[owner]=1 for exactly this cycle; gnt clears on exit; go to IDLE.
REQ-018 Latency: req seen in IDLE at cycle t gives gnt at t+1 (LOAD). RUN spans 256-val cycles, from t+2 to t+257-val. The done pulse is at t+258-val.
REQ-019 Boundary: val=8'hFF gives exactly 1 RUN cycle; val=8'h00 gives 256 RUN cycles; no wrap beyond 8'hFF is ever observed in RUN.
REQ-020 Abort: if the owner's req bit is low in LOAD or RUN, go to IDLE next cycle; gnt clears, no done pulse, ctr_rst=1.
REQ-021 A non-owner req during LOAD/RUN/DONE SHALL be ignored until IDLE; it is not queued.
REQ-022 A req still high in IDLE after done SHALL be treated as a new request.
REQ-023 busy, gnt and done SHALL never have more than one gnt/done bit high at a time.

Reset
REQ-024 rst SHALL override all states: state=IDLE, gnt=0, done=0, busy=0, latched value=0, ctr_rst=1, ctr_en=0, ctr_load=0.
REQ-025 rst asserted mid-RUN SHALL drop the run with no done pulse; a held req is re-arbitrated on the first IDLE cycle after rst falls.
REQ-026 The arbitration pointer SHALL reset so that requester 0 wins the first simultaneous request.

Configuration
REQ-027 Macro CNT_SCHED_RR_EN SHALL select the arbitration policy.
REQ-028 With CNT_SCHED_RR_EN defined: round-robin; on simultaneous req, grant the requester not served last; the pointer updates on each grant.
REQ-029 Without CNT_SCHED_RR_EN: fixed priority, requester 0 always wins; no pointer register.

Verification
REQ-030 req=01, val0=8'hFC -> gnt=01 at t+1; ctr_count FC,FD,FE,FF in RUN; done=01 single pulse at t+6; busy low at t+7.
REQ-031 req=10, val1=8'hFF -> 1 RUN cycle; done=10 at t+3.
REQ-032 req=11 held, both vals 8'hFE -> RR_EN: grants 01,10,01 alternate; without RR_EN: 01,01,01.
REQ-033 req=01, val0=8'h10; drop req[0] at 3rd RUN cycle -> IDLE next cycle, done stays 0, gnt=00, ctr_rst=1.
REQ-034 req=01, val0=8'h00; assert rst at the 100th RUN cycle -> all outputs at reset values next cycle, no done pulse; req=11 after rst -> gnt=01.
REQ-035 req=01 run in progress, req[1] pulses for 2 cycles mid-RUN -> ignored; only done=01 is produced.
